// File: rtl/freq_div_pkg.sv
// Shared types and constants for the divided-clock ratio checker.
// State encodings and nominal divider periods in reference cycles.
package freq_div_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE    = 2'd0;
   localparam state_t ARMED   = 2'd1;
   localparam state_t MEAS    = 2'd2;
   localparam state_t TIMEOUT = 2'd3;

   localparam int P2X = 2;
   localparam int P3X = 3;
   localparam int P4X = 4;
   localparam int P5X = 5;

endpackage

// File: rtl/freq_ratio_meas_edge_sync.sv
// Samples the divided clock into the reference domain and
// flags rising edges; s_o and rise_o are registered and aligned.
module edge_sync
   import freq_div_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic s_o,
   output logic rise_o
);

   logic s;
   logic s_d_q;
   logic rise_q;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign s = sig_i;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // shift the raw input through the sampling chain
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            sync_q <= '0;
         end else begin
            sync_q[0] <= sig_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sync_q[i] <= sync_q[i-1];
            end
         end
      end

      assign s = sync_q[SYNC_STAGES-1];
   end

   // delayed copy for edge detect, edge registered with its sample
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_d_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s_d_q  <= s;
         rise_q <= s & ~s_d_q;
      end
   end

   assign s_o    = s_d_q;
   assign rise_o = rise_q;

endmodule

// File: rtl/freq_ratio_meas.sv
// Measures period and high time of a divided clock in clk_in
// cycles, reports lock on a stable ratio and flags a dead clock.
module freq_ratio_meas
   import freq_div_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int MAX_PERIOD  = 255,
   parameter int LOCK_CNT    = 3
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             locked,
   output logic             err_timeout
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [MW-1:0]    LOCK_M  = MW'(LOCK_CNT);
   localparam logic [MW-1:0]    M_ONE   = MW'(1);

   logic s;
   logic rise;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [MW-1:0]    match_q, match_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [MW-1:0]    match_nxt;

   edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_in),
      .rst_i (rst),
      .sig_i (sig_in),
      .s_o   (s),
      .rise_o(rise)
   );

   // next state: counters, FSM, emission and lock tracking
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      period_d  = period_q;
      high_d    = high_q;
      match_d   = match_q;
      locked_d  = locked_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      match_nxt = M_ONE;

      if (rise) begin
         cnt_d  = ONE;
         hcnt_d = ONE;
      end else begin
         cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
         hcnt_d = (s && hcnt_q != CNT_MAX) ? hcnt_q + ONE : hcnt_q;
      end

      if (match_q != '0 && cnt_q == last_q) begin
         match_nxt = (match_q >= LOCK_M) ? LOCK_M : match_q + M_ONE;
      end

      if (!en) begin
         state_d  = IDLE;
         locked_d = 1'b0;
         err_d    = 1'b0;
         match_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = ARMED;
            end
            ARMED: begin
               if (rise) state_d = MEAS;
            end
            MEAS: begin
               if (rise) begin
                  period_d = cnt_q;
                  high_d   = hcnt_q;
                  last_d   = cnt_q;
                  valid_d  = 1'b1;
                  match_d  = match_nxt;
                  locked_d = (match_nxt >= LOCK_M);
               end else if (cnt_q == TMO) begin
                  state_d  = TIMEOUT;
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  match_d  = '0;
               end
            end
            TIMEOUT: begin
               if (rise) begin
                  state_d = MEAS;
                  err_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hcnt_q   <= '0;
         last_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         match_q  <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hcnt_q   <= hcnt_d;
         last_q   <= last_d;
         period_q <= period_d;
         high_q   <= high_d;
         match_q  <= match_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign period_out  = period_q;
   assign high_out    = high_q;
   assign meas_valid  = valid_q;
   assign locked      = locked_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_freq_ratio_meas.sv
// Self-checking bench for freq_ratio_meas: a period-level
// model queues expected measurements, a monitor pops them.
module tb_freq_ratio_meas;
   import freq_div_pkg::*;

   localparam int SYNC  = 2;
   localparam int CW    = 8;
   localparam int MAXP  = 20;
   localparam int LOCKN = 3;

   typedef struct {
      int p;
      int h;
      bit l;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          en;
   logic          sig_in;
   logic [CW-1:0] period_out;
   logic [CW-1:0] high_out;
   logic          meas_valid;
   logic          locked;
   logic          err_timeout;

   int   errors;
   int   checks;
   exp_t q[$];
   exp_t mon_e;
   bit   err_seen;

   bit m_prev;
   bit m_open;
   int m_len;
   int m_hi;
   int m_match;
   int m_last;

   freq_ratio_meas #(
      .SYNC_STAGES(SYNC),
      .CNT_W      (CW),
      .MAX_PERIOD (MAXP),
      .LOCK_CNT   (LOCKN)
   ) dut (
      .clk_in     (clk),
      .rst        (rst),
      .en         (en),
      .sig_in     (sig_in),
      .period_out (period_out),
      .high_out   (high_out),
      .meas_valid (meas_valid),
      .locked     (locked),
      .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard consumer
   always @(negedge clk) begin
      if (rst === 1'b0 && meas_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_meas: period_out=%0d, none expected",
                     period_out);
         end else begin
            mon_e = q.pop_front();
            checks++;
            if (period_out !== CW'(mon_e.p)) begin
               errors++;
               $display("FAIL meas_period: got %0d, expected %0d",
                        period_out, mon_e.p);
            end
            checks++;
            if (high_out !== CW'(mon_e.h)) begin
               errors++;
               $display("FAIL meas_high: got %0d, expected %0d",
                        high_out, mon_e.h);
            end
            checks++;
            if (locked !== mon_e.l) begin
               errors++;
               $display("FAIL meas_locked: got %0b, expected %0b",
                        locked, mon_e.l);
            end
         end
      end
      if (err_timeout === 1'b1) err_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected end");
      $fatal(1);
   end

   task automatic model_clear();
      m_prev  = 1'b0;
      m_open  = 1'b0;
      m_len   = 0;
      m_hi    = 0;
      m_match = 0;
      m_last  = 0;
   endtask

   task automatic model_bit(input logic b);
      bit r;
      r      = b && !m_prev;
      m_prev = b;
      if (!en) begin
         m_open  = 1'b0;
         m_match = 0;
      end else if (r) begin
         if (m_open) begin
            if (m_match == 0) m_match = 1;
            else if (m_len == m_last)
               m_match = (m_match >= LOCKN) ? LOCKN : m_match + 1;
            else m_match = 1;
            m_last = m_len;
            q.push_back('{m_len, m_hi, (m_match >= LOCKN)});
         end
         m_open = 1'b1;
         m_len  = 1;
         m_hi   = 1;
      end else if (m_open) begin
         m_len++;
         if (b) m_hi++;
         if (m_len > MAXP) begin
            m_open  = 1'b0;
            m_match = 0;
         end
      end
   endtask

   task automatic drive_bit(input logic b);
      @(negedge clk);
      sig_in = b;
      model_bit(b);
   endtask

   task automatic drive_pat(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < hi; i++) drive_bit(1'b1);
         for (int i = 0; i < lo; i++) drive_bit(1'b0);
      end
   endtask

   task automatic apply_reset();
      rst    = 1'b1;
      sig_in = 1'b0;
      en     = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_clear();
      repeat (2) drive_bit(1'b0);
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      sig_in = 1'b0;
      en     = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({period_out, high_out, meas_valid, locked, err_timeout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got p=%0d h=%0d v=%0b l=%0b e=%0b, expected all 0",
                  period_out, high_out, meas_valid, locked, err_timeout);
      end
      apply_reset();
   endtask

   task automatic test_2x();
      apply_reset();
      drive_pat(1, P2X - 1, 6);
      drive_bit(1'b1);
      repeat (5) drive_bit(1'b0);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL lock_2x: got %0b, expected 1", locked);
      end
   endtask

   task automatic test_latency();
      apply_reset();
      drive_pat(1, P3X - 1, 1);
      drive_bit(1'b1);
      repeat (3) drive_bit(1'b0);
      checks++;
      if (meas_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: got %0b, expected 0", meas_valid);
      end
      drive_bit(1'b0);
      checks++;
      if (meas_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency_due: got %0b, expected 1", meas_valid);
      end
      repeat (3) drive_bit(1'b0);
   endtask

   task automatic test_ratio_change();
      apply_reset();
      drive_pat(3, P5X - 3, 5);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL lock_5x: got %0b, expected 1", locked);
      end
      drive_pat(2, P4X - 2, 6);
      drive_bit(1'b1);
      repeat (5) drive_bit(1'b0);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL relock_4x: got %0b, expected 1", locked);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      drive_pat(1, 1, 4);
      drive_bit(1'b1);
      repeat (23) drive_bit(1'b0);
      checks++;
      if (err_timeout !== 1'b0 || locked !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: got e=%0b l=%0b, expected e=0 l=1",
                  err_timeout, locked);
      end
      drive_bit(1'b0);
      checks++;
      if (err_timeout !== 1'b1 || locked !== 1'b0) begin
         errors++;
         $display("FAIL timeout_hit: got e=%0b l=%0b, expected e=1 l=0",
                  err_timeout, locked);
      end
      repeat (10) drive_bit(1'b0);
      drive_bit(1'b1);
      repeat (3) drive_bit(1'b0);
      checks++;
      if (err_timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_hold: got %0b, expected 1", err_timeout);
      end
      drive_bit(1'b0);
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: got %0b, expected 0", err_timeout);
      end
      drive_bit(1'b1);
      repeat (5) drive_bit(1'b0);
   endtask

   task automatic test_max_period();
      apply_reset();
      err_seen = 1'b0;
      drive_pat(1, 1, 3);
      drive_pat(1, MAXP - 1, 1);
      drive_bit(1'b1);
      repeat (5) drive_bit(1'b0);
      checks++;
      if (err_seen !== 1'b0) begin
         errors++;
         $display("FAIL max_period_no_timeout: got %0b, expected 0", err_seen);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      drive_pat(1, 1, 4);
      drive_bit(1'b1);
      repeat (6) drive_bit(1'b0);
      checks++;
      if (locked !== 1'b1 || q.size() != 0) begin
         errors++;
         $display("FAIL pre_reset: got l=%0b pending=%0d, expected l=1 pending=0",
                  locked, q.size());
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({period_out, high_out, meas_valid, locked, err_timeout} !== '0) begin
         errors++;
         $display("FAIL async_reset: got p=%0d h=%0d v=%0b l=%0b e=%0b, expected all 0",
                  period_out, high_out, meas_valid, locked, err_timeout);
      end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      repeat (2) drive_bit(1'b0);
      drive_pat(2, 2, 3);
      drive_bit(1'b1);
      repeat (5) drive_bit(1'b0);
   endtask

   task automatic test_enable();
      apply_reset();
      drive_pat(1, 1, 4);
      drive_bit(1'b1);
      repeat (6) drive_bit(1'b0);
      en = 1'b0;
      drive_bit(1'b0);
      checks++;
      if (locked !== 1'b0 || period_out !== CW'(2) || high_out !== CW'(1)) begin
         errors++;
         $display("FAIL en_low: got l=%0b p=%0d h=%0d, expected l=0 p=2 h=1",
                  locked, period_out, high_out);
      end
      repeat (4) drive_bit(1'b0);
      en = 1'b1;
      repeat (2) drive_bit(1'b0);
      drive_pat(1, 1, 3);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL en_relock_early: got %0b, expected 0", locked);
      end
      drive_pat(1, 1, 1);
      drive_bit(1'b1);
      repeat (5) drive_bit(1'b0);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL en_relock: got %0b, expected 1", locked);
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      err_seen = 1'b0;
      rst      = 1'b1;
      en       = 1'b0;
      sig_in   = 1'b0;
      model_clear();
      test_reset();
      test_2x();
      test_latency();
      test_ratio_change();
      test_timeout();
      test_max_period();
      test_async_reset();
      test_enable();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_meas: got %0d pending, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
